// File: rtl/mv_result_collector.sv
// mv_result_collector
// Receiving end of the mv_mul_4x4_fp32 result stream. Results go into a
// DEPTH-entry FIFO and are presented downstream with a valid/ready handshake.
// The multiplier cannot be stalled, so this block hands out credits instead.
// The issuer may fire only while can_issue=1. A credit is counted against
// both stored entries and results still in flight, so a compliant issuer
// can never overflow the FIFO.
//
// Ports
//   clk, rst             clock; synchronous active-high reset
//   issue_fire           a vertex entered the multiplier this cycle
//   can_issue            credit available (registers only)
//   res_valid/res_id/res_x..res_w   multiplier result, FP32 stored bit-exact
//   dn_valid/dn_ready/dn_id/dn_x..dn_w   downstream handshake, FIFO head
//   occupancy, inflight  entries stored / issued but not yet returned
//   ovf_err              sticky: result dropped, or result with nothing in flight
//   seq_err              sticky: result id out of order
//   clear_err            clears both sticky flags
module mv_result_collector #(
  parameter int IDW   = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       issue_fire,
  output logic                       can_issue,
  input  logic                       res_valid,
  input  logic [IDW-1:0]             res_id,
  input  logic [31:0]                res_x,
  input  logic [31:0]                res_y,
  input  logic [31:0]                res_z,
  input  logic [31:0]                res_w,
  output logic                       dn_valid,
  input  logic                       dn_ready,
  output logic [IDW-1:0]             dn_id,
  output logic [31:0]                dn_x,
  output logic [31:0]                dn_y,
  output logic [31:0]                dn_z,
  output logic [31:0]                dn_w,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [$clog2(DEPTH+1)-1:0] inflight,
  output logic                       ovf_err,
  output logic                       seq_err,
  input  logic                       clear_err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [31:0]    x;
    logic [31:0]    y;
    logic [31:0]    z;
    logic [31:0]    w;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   occ, infl;
  logic [IDW-1:0]  exp_id;
  logic [CW:0]     credit_sum;
  logic            full, pop, push, drop, stray, infl_dec;

  assign full     = (occ == CW'(DEPTH));
  assign dn_valid = (occ != '0);
  assign pop      = dn_valid & dn_ready;
  // A pop in the same cycle frees the head slot, so a full FIFO still accepts.
  assign push     = res_valid & (~full | pop);
  assign drop     = res_valid & full & ~pop;
  assign stray    = res_valid & (infl == '0);
  assign infl_dec = res_valid & (infl != '0);

  assign credit_sum = {1'b0, occ} + {1'b0, infl};
  assign can_issue  = (credit_sum < (CW+1)'(DEPTH));

  // Head is read straight from storage; forced to zero when empty so stale
  // entries never appear on the outputs.
  assign head = mem[rd_ptr];
  always_comb begin
    dn_id = '0;
    dn_x  = '0;
    dn_y  = '0;
    dn_z  = '0;
    dn_w  = '0;
    if (dn_valid) begin
      dn_id = head.id;
      dn_x  = head.x;
      dn_y  = head.y;
      dn_z  = head.z;
      dn_w  = head.w;
    end
  end

  assign occupancy = occ;
  assign inflight  = infl;

  // Storage needs no reset: pointers and occupancy define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{id: res_id, x: res_x, y: res_y, z: res_z, w: res_w};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ     <= '0;
      infl    <= '0;
      exp_id  <= '0;
      ovf_err <= 1'b0;
      seq_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      occ  <= occ + CW'(push) - CW'(pop);
      infl <= infl + CW'(issue_fire) - CW'(infl_dec);
      // Always resync to the id just seen so one bad id flags only once.
      if (res_valid) exp_id <= res_id + IDW'(1);
      // Clear first; an error in the same cycle overrides it.
      if (clear_err) begin
        ovf_err <= 1'b0;
        seq_err <= 1'b0;
      end
      if (drop | stray)                    ovf_err <= 1'b1;
      if (res_valid && (res_id != exp_id)) seq_err <= 1'b1;
    end
  end
endmodule
